// File: rtl/pedestrian_walk_ctrl_pkg.sv
// Light codes and pedestrian FSM encoding, shared with the upstream signal controller.
package pedestrian_walk_ctrl_pkg;

    typedef enum logic [1:0] {
        RED       = 2'b00,
        GREEN     = 2'b01,
        YELLOW    = 2'b10,
        LIGHT_BAD = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        DONT_WALK = 2'b00,
        WALK      = 2'b01,
        CLEAR     = 2'b10
    } ped_state_t;

    localparam int CNT_W = 4;

    function automatic logic is_red(input logic [1:0] code);
        return code == RED;
    endfunction

endpackage

// File: rtl/pedestrian_walk_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for the asynchronous push-button followed by a rising-edge detector.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/pedestrian_walk_ctrl.sv
// Pedestrian walk/don't-walk controller slaved to the vehicle light code.
// Build option: define PED_FLASH_EN to flash the don't-walk lamp during clearance.
module pedestrian_walk_ctrl
    import pedestrian_walk_ctrl_pkg::*;
#(
    parameter int WALK_CYCLES  = 2,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             abort
);

    localparam logic [CNT_W-1:0] LOAD        = CNT_W'(WALK_CYCLES + CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_AT    = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_FIRST = CNT_W'(CLEAR_CYCLES - 1);

    ped_state_t       state;
    ped_state_t       state_next;
    logic [CNT_W-1:0] countdown_next;
    logic             req_next;
    logic             abort_next;
    logic [1:0]       light_prev;
    logic             btn_rise;
    logic             red_entry;

    btn_sync_edge u_btn_sync_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (ped_btn),
        .rise  (btn_rise)
    );

    assign red_entry = is_red(light) && !is_red(light_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= DONT_WALK;
            countdown   <= '0;
            req_pending <= 1'b0;
            abort       <= 1'b0;
            light_prev  <= RED;
        end else begin
            state       <= state_next;
            countdown   <= countdown_next;
            req_pending <= req_next;
            abort       <= abort_next;
            light_prev  <= light;
        end
    end

    // A non-red code during a crossing wins over the normal countdown progression.
    always_comb begin
        state_next     = state;
        countdown_next = countdown;
        req_next       = req_pending | btn_rise;
        abort_next     = 1'b0;
        case (state)
            DONT_WALK: begin
                if (red_entry && req_pending) begin
                    state_next     = WALK;
                    countdown_next = LOAD;
                    req_next       = 1'b0;
                end
            end
            WALK: begin
                if (!is_red(light)) begin
                    state_next     = DONT_WALK;
                    countdown_next = '0;
                    abort_next     = 1'b1;
                end else begin
                    countdown_next = countdown - 1'b1;
                    if (countdown == CLEAR_AT) begin
                        state_next = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (!is_red(light)) begin
                    state_next     = DONT_WALK;
                    countdown_next = '0;
                    abort_next     = 1'b1;
                end else if (countdown == '0) begin
                    state_next     = DONT_WALK;
                end else begin
                    countdown_next = countdown - 1'b1;
                end
            end
            default: begin
                state_next     = DONT_WALK;
                countdown_next = '0;
            end
        endcase
    end

    assign walk = (state == WALK);

`ifdef PED_FLASH_EN
    // Lamp is lit on the first clearance cycle and alternates with countdown parity.
    assign dont_walk = (state == CLEAR) ? ~(countdown[0] ^ CLEAR_FIRST[0]) : (state != WALK);
`else
    assign dont_walk = (state != WALK);
`endif

endmodule
